// File: rtl/vp_pkg.sv
// Shared definitions for the banked data-memory responder.
// Default geometry, latencies, state encoding and the write opcode value.
package vp_pkg;

    localparam int MB_NBANK    = 8;
    localparam int MB_DEPTH    = 64;
    localparam int MB_DW       = 32;
    localparam int MB_BW       = $clog2(MB_NBANK);
    localparam int MB_AW       = $clog2(MB_DEPTH);
    localparam int MB_RD_LAT   = 2;
    localparam int MB_WR_LAT   = 1;
    localparam int MB_RECOVERY = 2;

    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ACK   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/mem_bank_ctrl_if.sv
// MCN <-> MEM request/ack bus.
// master = mcn side (drives request), slave = memory side (drives ack/data).
interface mem_bank_ctrl_if
    import vp_pkg::*;
#(
    parameter int NBANK = MB_NBANK,
    parameter int DEPTH = MB_DEPTH,
    parameter int DW    = MB_DW
);

    localparam int BW = $clog2(NBANK);
    localparam int AW = $clog2(DEPTH);

    logic             reqMEM;
    logic             rwMEM;
    logic [AW-1:0]    addrMEM;
    logic [BW-1:0]    bankSelect;
    logic [DW-1:0]    doutMCN;
    logic [DW-1:0]    doutMEM;
    logic             ready;
    logic             ackMEM;
    logic [NBANK-1:0] bank_busy;

    modport master (
        output reqMEM,
        output rwMEM,
        output addrMEM,
        output bankSelect,
        output doutMCN,
        input  doutMEM,
        input  ready,
        input  ackMEM,
        input  bank_busy
    );

    modport slave (
        input  reqMEM,
        input  rwMEM,
        input  addrMEM,
        input  bankSelect,
        input  doutMCN,
        output doutMEM,
        output ready,
        output ackMEM,
        output bank_busy
    );

endinterface

// File: rtl/bank_recovery_timer.sv
// Per-bank recovery counter: loaded on ack, counts down to 0, saturates.
// Ports: clk, reset (sync, active-high), i_load, o_busy (counter nonzero).
module bank_recovery_timer
    import vp_pkg::*;
#(
    parameter int RECOVERY = MB_RECOVERY
)(
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    output logic o_busy
);

    localparam int RW = (RECOVERY > 0) ? $clog2(RECOVERY + 1) : 1;

    logic [RW-1:0] r_cnt;

    // A load overrides the decrement in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= RW'(RECOVERY);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/mem_bank_ctrl.sv
// Banked data memory responder with access latency and per-bank recovery.
// Ports: clk, reset (sync, active-high), bus (slave side of mem_bank_ctrl_if).
module mem_bank_ctrl
    import vp_pkg::*;
#(
    parameter int NBANK    = MB_NBANK,
    parameter int DEPTH    = MB_DEPTH,
    parameter int DW       = MB_DW,
    parameter int RD_LAT   = MB_RD_LAT,
    parameter int WR_LAT   = MB_WR_LAT,
    parameter int RECOVERY = MB_RECOVERY
)(
    input  logic           clk,
    input  logic           reset,
    mem_bank_ctrl_if.slave bus
);

    localparam int BW = $clog2(NBANK);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = BW + AW;
    localparam int LW = 8;

    state_t        r_state;
    state_t        w_next;
    logic [LW-1:0] r_cnt;
    logic          r_rw;
    logic [AW-1:0] r_addr;
    logic [BW-1:0] r_bank;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_dout;
    logic [DW-1:0] r_mem [NBANK*DEPTH];

    logic             w_capture;
    logic             w_enter_ack;
    logic             w_direct;
    logic             w_op_rw;
    logic [BW-1:0]    w_op_bank;
    logic [AW-1:0]    w_op_addr;
    logic [DW-1:0]    w_op_wdata;
    logic [IW-1:0]    w_idx;
    logic [LW-1:0]    w_lat_m1;
    logic [NBANK-1:0] w_busy;
    logic [NBANK-1:0] w_load;

    assign w_lat_m1 = (bus.rwMEM == RW_WRITE) ? LW'(WR_LAT - 1)
                                              : LW'(RD_LAT - 1);

    assign w_capture = (r_state == ST_IDLE) && bus.reqMEM
                       && !w_busy[bus.bankSelect];

    // A single-cycle access enters ACK on the capture edge itself,
    // so the operands come straight from the bus in that case.
    assign w_direct   = (r_state == ST_IDLE);
    assign w_op_rw    = w_direct ? bus.rwMEM      : r_rw;
    assign w_op_bank  = w_direct ? bus.bankSelect : r_bank;
    assign w_op_addr  = w_direct ? bus.addrMEM    : r_addr;
    assign w_op_wdata = w_direct ? bus.doutMCN    : r_wdata;
    assign w_idx      = {w_op_bank, w_op_addr};

    // cnt holds the edges remaining minus one; BUSY leaves on the
    // edge that would take it to zero.
    always_comb begin
        w_next      = r_state;
        w_enter_ack = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    if (w_lat_m1 == '0) begin
                        w_next      = ST_ACK;
                        w_enter_ack = 1'b1;
                    end else begin
                        w_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == LW'(1)) begin
                    w_next      = ST_ACK;
                    w_enter_ack = 1'b1;
                end
            end
            ST_ACK: begin
                w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!bus.reqMEM) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_bank  <= '0;
            r_wdata <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_rw    <= bus.rwMEM;
                r_addr  <= bus.addrMEM;
                r_bank  <= bus.bankSelect;
                r_wdata <= bus.doutMCN;
                r_cnt   <= w_lat_m1;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_enter_ack && (w_op_rw != RW_WRITE)) begin
                r_dout <= r_mem[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NBANK * DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_enter_ack && (w_op_rw == RW_WRITE)) begin
            r_mem[w_idx] <= w_op_wdata;
        end
    end

    for (genvar g = 0; g < NBANK; g++) begin : g_rec
        assign w_load[g] = w_enter_ack && (w_op_bank == BW'(g));

        bank_recovery_timer #(
            .RECOVERY (RECOVERY)
        ) u_rec (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_load[g]),
            .o_busy (w_busy[g])
        );
    end

    assign bus.ready     = (r_state == ST_IDLE);
    assign bus.ackMEM    = (r_state == ST_ACK);
    assign bus.doutMEM   = r_dout;
    assign bus.bank_busy = w_busy;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Directed bench for mem_bank_ctrl.
// Drives the master side of the bus and checks latency, data and recovery.
module tb_mem_bank_ctrl;

    import vp_pkg::*;

    localparam int REC = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_bank_ctrl_if bus ();

    mem_bank_ctrl #(
        .RECOVERY (REC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where ackMEM is seen.
    task automatic do_req(input bit rw, input int bank, input int addr,
                          input logic [31:0] wd, input bit keep,
                          output int waits, output int lat,
                          output logic [31:0] rd);
        bit ok;
        bus.rwMEM      = rw;
        bus.bankSelect = 3'(bank);
        bus.addrMEM    = 6'(addr);
        bus.doutMCN    = wd;
        bus.reqMEM     = 1'b1;
        waits = 0;
        ok    = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.ready && !bus.bank_busy[bank]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            waits++;
        end
        if (!ok) chk("capture_timeout", 32'd0, 32'd1);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.ackMEM) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ack_timeout", 32'd0, 32'd1);
        rd = bus.doutMEM;
        if (!keep) bus.reqMEM = 1'b0;
    endtask

    task automatic drain();
        bus.reqMEM = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          l;
        int          acks;
        int          rdy;
        bit          ok;
        logic [31:0] d;

        bus.reqMEM     = 1'b0;
        bus.rwMEM      = 1'b0;
        bus.addrMEM    = '0;
        bus.bankSelect = '0;
        bus.doutMCN    = '0;
        reset          = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_ack", 32'(bus.ackMEM), 32'd0);
        chk("rst_dout", bus.doutMEM, 32'd0);
        chk("rst_busy", 32'(bus.bank_busy), 32'd0);

        do_req(1'b0, 3, 5, 32'd0, 1'b0, w, l, d);
        chk("rst_rd_lat", 32'(l), 32'd2);
        chk("rst_rd_data", d, 32'd0);
        drain();

        do_req(1'b1, 2, 10, 32'hDEADBEEF, 1'b0, w, l, d);
        chk("wr_wait", 32'(w), 32'd0);
        chk("wr_lat", 32'(l), 32'd1);
        chk("wr_dout_held", d, 32'd0);
        chk("wr_busy2", 32'(bus.bank_busy[2]), 32'd1);
        drain();
        do_req(1'b0, 2, 10, 32'd0, 1'b0, w, l, d);
        chk("rd_wait", 32'(w), 32'(REC - 2));
        chk("rd_lat", 32'(l), 32'd2);
        chk("rd_data", d, 32'hDEADBEEF);
        drain();

        do_req(1'b1, 7, 63, 32'hCAFEF00D, 1'b0, w, l, d);
        drain();
        do_req(1'b0, 7, 63, 32'd0, 1'b0, w, l, d);
        chk("edge_rd_data", d, 32'hCAFEF00D);
        drain();
        do_req(1'b0, 7, 62, 32'd0, 1'b0, w, l, d);
        chk("edge_nbr_data", d, 32'd0);
        drain();

        do_req(1'b0, 4, 7, 32'd0, 1'b0, w, l, d);
        chk("b2b_busy4", 32'(bus.bank_busy[4]), 32'd1);
        drain();
        chk("b2b_ready", 32'(bus.ready), 32'd1);
        do_req(1'b0, 4, 8, 32'd0, 1'b0, w, l, d);
        chk("b2b_wait", 32'(w), 32'(REC - 2));
        chk("b2b_gap", 32'((2 + w) >= REC), 32'd1);
        chk("b2b_lat", 32'(l), 32'd2);
        drain();

        do_req(1'b0, 1, 3, 32'd0, 1'b0, w, l, d);
        drain();
        chk("xb_busy1", 32'(bus.bank_busy[1]), 32'd1);
        do_req(1'b0, 6, 4, 32'd0, 1'b0, w, l, d);
        chk("xb_wait6", 32'(w), 32'd0);
        chk("xb_lat6", 32'(l), 32'd2);
        drain();

        do_req(1'b0, 5, 0, 32'd0, 1'b1, w, l, d);
        acks = 1;
        rdy  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.ackMEM) acks++;
            if (bus.ready) rdy++;
        end
        chk("hold_acks", 32'(acks), 32'd1);
        chk("hold_ready", 32'(rdy), 32'd0);
        bus.reqMEM = 1'b0;
        @(negedge clk);
        chk("hold_release", 32'(bus.ready), 32'd1);

        bus.rwMEM      = 1'b1;
        bus.bankSelect = 3'd0;
        bus.addrMEM    = 6'd0;
        bus.doutMCN    = 32'h12345678;
        bus.reqMEM     = 1'b1;
        chk("rstw_ready", 32'(bus.ready && !bus.bank_busy[0]), 32'd1);
        @(negedge clk);
        reset      = 1'b1;
        bus.reqMEM = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rstw_ack", 32'(bus.ackMEM), 32'd0);
        chk("rstw_ready2", 32'(bus.ready), 32'd1);
        chk("rstw_busy", 32'(bus.bank_busy), 32'd0);
        do_req(1'b0, 0, 0, 32'd0, 1'b0, w, l, d);
        chk("rstw_rd_data", d, 32'd0);
        drain();

        do_req(1'b1, 5, 1, 32'hA5A5A5A5, 1'b0, w, l, d);
        drain();
        bus.rwMEM      = 1'b0;
        bus.bankSelect = 3'd5;
        bus.addrMEM    = 6'd1;
        bus.reqMEM     = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.ready && !bus.bank_busy[5]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("rstr_capture_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("rstr_busy_state", 32'(bus.ready), 32'd0);
        reset      = 1'b1;
        bus.reqMEM = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        acks  = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.ackMEM) acks++;
            @(negedge clk);
        end
        chk("rstr_no_ack", 32'(acks), 32'd0);
        chk("rstr_dout", bus.doutMEM, 32'd0);
        do_req(1'b0, 5, 1, 32'd0, 1'b0, w, l, d);
        chk("rstr_rd_data", d, 32'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
